// File: rtl/race_sequencer.sv
// Game-flow controller for the racer pipeline: splash -> car select -> control select
// -> countdown -> race -> finish, driven by button edges, frame-end and lap pulses.
module race_sequencer #(
  parameter int NUM_CARS      = 4,
  parameter int LAPS          = 3,
  parameter int COUNT_FRAMES  = 60,
  parameter int FINISH_FRAMES = 300
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        frame_ended,
  input  logic [3:0]  key,
  input  logic        lap_cross,
  output logic        splash_visible,
  output logic        car_select_visible,
  output logic        control_select_visible,
  output logic        track_visible,
  output logic        player_visible,
  output logic        race_active,
  output logic [1:0]  car_sel,
  output logic        ctl_sel,
  output logic [1:0]  countdown,
  output logic [2:0]  lap_count,
  output logic [15:0] race_time
);

  localparam int FMAX = (COUNT_FRAMES > FINISH_FRAMES) ? COUNT_FRAMES : FINISH_FRAMES;
  localparam int CW   = $clog2(FMAX + 1);
  localparam logic [CW-1:0] CF_LAST  = CW'(COUNT_FRAMES - 1);
  localparam logic [CW-1:0] FF_LAST  = CW'(FINISH_FRAMES - 1);
  localparam logic [1:0]    CAR_LAST = 2'(NUM_CARS - 1);
  localparam logic [2:0]    LAPS_W   = 3'(LAPS);

  typedef enum logic [2:0] {
    S_SPLASH, S_CAR_SEL, S_CTL_SEL, S_COUNTDOWN, S_RACE, S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    key_q;
  logic [1:0]    car_q, car_d;
  logic          ctl_q, ctl_d;
  logic [1:0]    cd_q, cd_d;
  logic [2:0]    lap_q, lap_d;
  logic [15:0]   time_q, time_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    vis_q, vis_d;

  logic [3:0] press;
  logic       p_u, p_d, p_r, p_l;

  // key is {R, L, D, U}; only the highest-priority press (U > D > R > L) acts
  assign press = key & ~key_q;
  assign p_u   = press[0];
  assign p_d   = press[1] & ~press[0];
  assign p_r   = press[3] & ~|press[1:0];
  assign p_l   = press[2] & ~press[3] & ~|press[1:0];

  always_comb begin
    state_d = state_q;
    car_d   = car_q;
    ctl_d   = ctl_q;
    cd_d    = cd_q;
    lap_d   = lap_q;
    time_d  = time_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_SPLASH: begin
        if (|press) state_d = S_CAR_SEL;
      end
      S_CAR_SEL: begin
        if (p_u)      state_d = S_CTL_SEL;
        else if (p_d) state_d = S_SPLASH;
        else if (p_r) car_d = (car_q == CAR_LAST) ? 2'd0 : car_q + 2'd1;
        else if (p_l) car_d = (car_q == 2'd0) ? CAR_LAST : car_q - 2'd1;
      end
      S_CTL_SEL: begin
        if (p_u) begin
          state_d = S_COUNTDOWN;
          cd_d    = 2'd3;
          cnt_d   = '0;
        end else if (p_d) begin
          state_d = S_CAR_SEL;
        end else if (p_r || p_l) begin
          ctl_d = ~ctl_q;
        end
      end
      S_COUNTDOWN: begin
        if (frame_ended) begin
          if (cnt_q == CF_LAST) begin
            cnt_d = '0;
            if (cd_q == 2'd1) begin
              state_d = S_RACE;
              cd_d    = 2'd0;
              lap_d   = 3'd0;
              time_d  = 16'd0;
            end else begin
              cd_d = cd_q - 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_RACE: begin
        if (frame_ended && (time_q != 16'hFFFF)) time_d = time_q + 16'd1;
        if (lap_cross) begin
          lap_d = lap_q + 3'd1;
          if (lap_q + 3'd1 == LAPS_W) begin
            state_d = S_FINISH;
            cnt_d   = '0;
          end
        end
      end
      S_FINISH: begin
        if (p_u) begin
          state_d = S_SPLASH;
        end else if (frame_ended) begin
          if (cnt_q == FF_LAST) begin
            state_d = S_SPLASH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_SPLASH;
    endcase
  end

  // visibility flags {splash, car, ctl, track, player, active}, registered from next state
  always_comb begin
    vis_d = 6'b100000;
    case (state_d)
      S_SPLASH:    vis_d = 6'b100000;
      S_CAR_SEL:   vis_d = 6'b010000;
      S_CTL_SEL:   vis_d = 6'b001000;
      S_COUNTDOWN: vis_d = 6'b000110;
      S_RACE:      vis_d = 6'b000111;
      S_FINISH:    vis_d = 6'b000110;
      default:     vis_d = 6'b100000;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q <= S_SPLASH;
      key_q   <= 4'b1111;
      car_q   <= 2'd0;
      ctl_q   <= 1'b0;
      cd_q    <= 2'd0;
      lap_q   <= 3'd0;
      time_q  <= 16'd0;
      cnt_q   <= '0;
      vis_q   <= 6'b100000;
    end else begin
      state_q <= state_d;
      key_q   <= key;
      car_q   <= car_d;
      ctl_q   <= ctl_d;
      cd_q    <= cd_d;
      lap_q   <= lap_d;
      time_q  <= time_d;
      cnt_q   <= cnt_d;
      vis_q   <= vis_d;
    end
  end

  assign splash_visible         = vis_q[5];
  assign car_select_visible     = vis_q[4];
  assign control_select_visible = vis_q[3];
  assign track_visible          = vis_q[2];
  assign player_visible         = vis_q[1];
  assign race_active            = vis_q[0];
  assign car_sel                = car_q;
  assign ctl_sel                = ctl_q;
  assign countdown              = cd_q;
  assign lap_count              = lap_q;
  assign race_time              = time_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Scoreboard bench for race_sequencer: a rule-level game model predicts every cycle's
// outputs into a queue that an independent monitor drains after each clock edge.
module tb_race_sequencer;

  localparam int NC = 3;
  localparam int LP = 2;
  localparam int CF = 2;
  localparam int FF = 5;

  localparam int PH_SPLASH = 0;
  localparam int PH_CAR    = 1;
  localparam int PH_CTL    = 2;
  localparam int PH_CD     = 3;
  localparam int PH_RACE   = 4;
  localparam int PH_FIN    = 5;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_ended = 1'b0;
  logic        lap_cross = 1'b0;
  logic [3:0]  key = 4'b0001;
  logic        splash_visible, car_select_visible, control_select_visible;
  logic        track_visible, player_visible, race_active;
  logic [1:0]  car_sel;
  logic        ctl_sel;
  logic [1:0]  countdown;
  logic [2:0]  lap_count;
  logic [15:0] race_time;

  race_sequencer #(
    .NUM_CARS(NC), .LAPS(LP), .COUNT_FRAMES(CF), .FINISH_FRAMES(FF)
  ) dut (
    .pclk(pclk), .rst(rst), .frame_ended(frame_ended), .key(key), .lap_cross(lap_cross),
    .splash_visible(splash_visible), .car_select_visible(car_select_visible),
    .control_select_visible(control_select_visible), .track_visible(track_visible),
    .player_visible(player_visible), .race_active(race_active), .car_sel(car_sel),
    .ctl_sel(ctl_sel), .countdown(countdown), .lap_count(lap_count), .race_time(race_time)
  );

  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_bad = 0;
  logic [29:0] exp_q[$];
  logic [29:0] act_vec;
  logic [29:0] mon_exp;

  assign act_vec = {splash_visible, car_select_visible, control_select_visible, track_visible,
                    player_visible, race_active, car_sel, ctl_sel, countdown, lap_count, race_time};

  // game model: phase plus plain frame/lap tallies
  int m_ph, m_car, m_ctl, m_cdf, m_laps, m_rt, m_ff;
  logic [3:0] m_kprev;

  function automatic logic [29:0] m_out();
    int cd;
    int rt;
    cd = (m_ph == PH_CD) ? 3 - m_cdf / CF : 0;
    rt = (m_rt > 65535) ? 65535 : m_rt;
    return {m_ph == PH_SPLASH, m_ph == PH_CAR, m_ph == PH_CTL, m_ph >= PH_CD, m_ph >= PH_CD,
            m_ph == PH_RACE, 2'(m_car), 1'(m_ctl), 2'(cd), 3'(m_laps), 16'(rt)};
  endfunction

  task automatic m_reset();
    m_ph = PH_SPLASH; m_car = 0; m_ctl = 0; m_cdf = 0; m_laps = 0; m_rt = 0; m_ff = 0;
    m_kprev = 4'b1111;
  endtask

  task automatic m_step(input logic [3:0] k, input logic fe, input logic lc);
    logic [3:0] pr;
    byte act;
    pr = k & ~m_kprev;
    m_kprev = k;
    act = pr[0] ? "U" : pr[1] ? "D" : pr[3] ? "R" : pr[2] ? "L" : "-";
    case (m_ph)
      PH_SPLASH: if (pr != 4'b0) m_ph = PH_CAR;
      PH_CAR: begin
        if (act == "U") m_ph = PH_CTL;
        else if (act == "D") m_ph = PH_SPLASH;
        else if (act == "R") m_car = (m_car + 1) % NC;
        else if (act == "L") m_car = (m_car + NC - 1) % NC;
      end
      PH_CTL: begin
        if (act == "U") begin m_ph = PH_CD; m_cdf = 0; end
        else if (act == "D") m_ph = PH_CAR;
        else if (act == "R" || act == "L") m_ctl = 1 - m_ctl;
      end
      PH_CD: if (fe) begin
        m_cdf++;
        if (m_cdf == 3 * CF) begin m_ph = PH_RACE; m_laps = 0; m_rt = 0; end
      end
      PH_RACE: begin
        if (fe) m_rt++;
        if (lc) begin
          m_laps++;
          if (m_laps == LP) begin m_ph = PH_FIN; m_ff = 0; end
        end
      end
      default: begin
        if (act == "U") m_ph = PH_SPLASH;
        else if (fe) begin
          m_ff++;
          if (m_ff == FF) m_ph = PH_SPLASH;
        end
      end
    endcase
  endtask

  task automatic check(input string nm, input logic [29:0] a, input logic [29:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] k, input logic fe, input logic lc);
    @(negedge pclk);
    rst = r; key = k; frame_ended = fe; lap_cross = lc;
    if (!r) m_reset();
    else m_step(k, fe, lc);
    exp_q.push_back(m_out());
  endtask

  task automatic tap(input logic [3:0] k);
    step(1'b1, k, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic to_race();
    tap(4'b0001); tap(4'b0001); tap(4'b0001);
    repeat (3 * CF) step(1'b1, 4'b0000, 1'b1, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge pclk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("cycle", act_vec, mon_exp);
      end
    end
  end

  initial begin
    logic [3:0] kcur;
    m_reset();
    repeat (3) @(negedge pclk);
    #1 check("reset", act_vec, m_out());

    // U held through reset release must not count as a press
    repeat (3) step(1'b1, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    tap(4'b0001);
    // car select: L wraps, R advances, U beats R
    tap(4'b0100);
    tap(4'b1000);
    tap(4'b1000);
    tap(4'b1001);
    // control select
    tap(4'b1000);
    tap(4'b0010);
    tap(4'b0001);
    tap(4'b0001);
    // countdown with random keys that must be ignored
    for (int i = 0; i < 3 * CF; i++) begin
      step(1'b1, 4'($urandom), 1'b0, 1'b0);
      step(1'b1, 4'($urandom), 1'b1, 1'b0);
    end
    step(1'b1, 4'b0000, 1'b1, 1'b1);
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 1'b1);
    repeat (FF) step(1'b1, 4'b0000, 1'b1, 1'b0);

    // saturation of race_time
    to_race();
    repeat (65540) step(1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    step(1'b1, 4'b0000, 1'b1, 1'b1);
    tap(4'b0001);

    // asynchronous reset mid-race, checked between clock edges
    to_race();
    repeat (4) step(1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    @(posedge pclk);
    #3 rst = 1'b0;
    m_reset();
    #1 check("async_reset", act_vec, m_out());
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);

    kcur = 4'b0000;
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) kcur = 4'($urandom);
      step($urandom_range(0, 499) != 0, kcur,
           $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
    end

    repeat (3) @(posedge pclk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/race_sequencer.md
# race_sequencer

Game-flow controller for the racer video pipeline. Replaces the free-running screen FSM: steps through splash, car select, control select, start countdown, race and finish screens from debounced button edges and frame-end pulses. Drives the visibility enables of the menu, track and player draw stages. Exports the car/control choice, countdown digit, lap count and race timer to the car controller and overlays.

## Interface
Parameters:
- NUM_CARS, 4: selectable cars, 1..4; car_sel wraps modulo NUM_CARS.
- LAPS, 3: laps to finish, 1..7.
- COUNT_FRAMES, 60: frames per countdown digit, ≥1.
- FINISH_FRAMES, 300: frames on finish screen before auto-return, ≥1.

Ports:
- pclk  in  1  pixel clock (65 MHz); single clock domain.
- rst  in  1  asynchronous, active-low reset.
- frame_ended  in  1  one-cycle pulse per video frame.
- key  in  4  debounced button levels {R, L, D, U}.
- lap_cross  in  1  one-cycle pulse when the player crosses the finish line.
- splash_visible  out  1  splash screen enable.
- car_select_visible  out  1  car-select screen enable.
- control_select_visible  out  1  control-select screen enable.
- track_visible  out  1  track layer enable.
- player_visible  out  1  car sprite enable.
- race_active  out  1  car_ctl movement enable.
- car_sel  out  2  chosen car index.
- ctl_sel  out  1  0 = buttons, 1 = keyboard.
- countdown  out  2  digit shown (3, 2, 1); 0 outside COUNTDOWN.
- lap_count  out  3  completed laps.
- race_time  out  16  frames elapsed in RACE, saturating.

## Operation
- Key edges: key_q registers key each cycle; press = key & ~key_q. key_q resets to 4'b1111, so a key held through reset release produces no press.
- Press priority when several fire in one cycle: U > D > R > L; only the highest is acted on.
- States and transitions:
  - SPLASH: any press -> CAR_SEL.
  - CAR_SEL: R: car_sel+1 mod NUM_CARS. L: car_sel−1 mod NUM_CARS (0 -> NUM_CARS−1). U -> CTL_SEL. D -> SPLASH.
  - CTL_SEL: R or L toggles ctl_sel. U -> COUNTDOWN. D -> CAR_SEL.
  - COUNTDOWN: on entry countdown=3 and frame counter=0. Each frame_ended increments the counter. At COUNT_FRAMES the counter clears and countdown decrements. A decrement from 1 -> RACE. Keys ignored.
  - RACE: on entry lap_count=0 and race_time=0. frame_ended: race_time+1, saturating at 16'hFFFF. lap_cross: lap_count+1. Reaching LAPS -> FINISH. Keys ignored.
  - FINISH: lap_count and race_time frozen. Leaves -> SPLASH on a U press or after FINISH_FRAMES frame_ended pulses, whichever comes first.
- Visibility decode:
  - SPLASH: splash_visible only.
  - CAR_SEL: car_select_visible only.
  - CTL_SEL: control_select_visible only.
  - COUNTDOWN, RACE, FINISH: track_visible and player_visible.
  - race_active = 1 only in RACE.
- car_sel and ctl_sel persist across races and clear only on reset.
- lap_cross outside RACE is ignored.
- frame_ended and lap_cross in the same cycle are both applied.
- A lap_cross that completes the last lap takes priority; race_time still counts that cycle's frame.

## Timing
- All outputs registered; each updates on the same pclk edge as the state register.
- Latency: a key first sampled high at edge N produces a state/output change at edge N. The effect is visible in the cycle after edge N. The next press needs key low for at least one cycle.
- frame_ended / lap_cross sampled at edge N are reflected after edge N.
- Reset values:
  - state SPLASH; splash_visible=1; all other visibility flags 0.
  - race_active=0, car_sel=0, ctl_sel=0, countdown=0, lap_count=0, race_time=0.
  - internal counters 0; key_q=4'b1111.
- Reset assertion mid-operation returns everything to reset values asynchronously, including mid-countdown and mid-race.
- COUNTDOWN lasts exactly 3·COUNT_FRAMES frame_ended pulses.

## Test plan
- Reset with key=4'b0001 held, then release reset: stays in SPLASH. Release U, then press U: next cycle car_select_visible=1, splash_visible=0.
- CAR_SEL with NUM_CARS=3: L press gives car_sel=2. Then R, R gives 2->0->1. U and R pressed in the same cycle: CTL_SEL entered, car_sel stays 1.
- CTL_SEL: R toggles ctl_sel to 1. D returns to CAR_SEL with car_sel kept. U, then U again: COUNTDOWN, countdown=3, track_visible=player_visible=1, race_active=0.
- COUNTDOWN with COUNT_FRAMES=2: countdown 3,3,2,2,1,1 over 6 frames. race_active=1 right after the 6th frame_ended. Keys ignored throughout.
- RACE with LAPS=2: lap_cross pulses give lap_count 1 then 2, then FINISH with race_active=0. Race_time forced near 16'hFFFF saturates and never wraps. Same-cycle frame_ended + lap_cross applies both.
- FINISH: U press or FINISH_FRAMES frames returns to SPLASH. Async reset asserted mid-RACE: all outputs return to reset values without waiting for pclk.
